// File: rtl/vend_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vend_seq_ctrl
// Description : Coin-operated vending sequencer: collects 5/10 coins, drives
//               the dispenser handshake with timeout, and pays out change.
// Revision    : 1.0  initial release
// ============================================================================
module vend_seq_ctrl #(
    parameter int PRICE       = 15,
    parameter int MAX_CREDIT  = 25,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in5,
    input  logic       in10,
    input  logic       cancel,
    input  logic       disp_ack,
    input  logic       chg_ack,
    output logic       disp_req,
    output logic       chg_req,
    output logic       out,
    output logic       coin_rej,
    output logic       fault,
    output logic [4:0] credit,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam int              c_TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [4:0]      c_PRICE    = 5'(PRICE);
    localparam logic [5:0]      c_MAX      = 6'(MAX_CREDIT);
    localparam logic [4:0]      c_COIN5    = 5'd5;
    localparam logic [4:0]      c_COIN10   = 5'd10;

    state_t               r_state_q;
    state_t               w_state_d;
    logic [4:0]           r_credit_q;
    logic [4:0]           w_credit_d;
    logic [c_TMO_W-1:0]   r_tmo_q;
    logic [c_TMO_W-1:0]   w_tmo_d;
    logic                 r_disp_req_q;
    logic                 w_disp_req_d;
    logic                 r_chg_req_q;
    logic                 w_chg_req_d;
    logic                 r_out_q;
    logic                 w_out_d;
    logic                 r_coin_rej_q;
    logic                 w_coin_rej_d;
    logic                 r_fault_q;
    logic                 w_fault_d;
    logic                 r_busy_q;
    logic                 w_busy_d;

    logic                 w_coin_any;
    logic                 w_coin_one;
    logic [4:0]           w_coin_val;
    logic [5:0]           w_coin_sum;
    logic                 w_can_take;
    logic                 w_coin_ok;
    logic [4:0]           w_after_vend;

    assign w_coin_any   = in5 | in10;
    assign w_coin_one   = in5 ^ in10;
    assign w_coin_val   = in10 ? c_COIN10 : c_COIN5;
    assign w_coin_sum   = {1'b0, r_credit_q} + {1'b0, w_coin_val};
    assign w_can_take   = (r_state_q == S_IDLE) || (r_state_q == S_COLLECT);
    assign w_coin_ok    = w_coin_one && w_can_take && (w_coin_sum <= c_MAX);
    assign w_after_vend = r_credit_q - c_PRICE;

    always_comb begin
        w_state_d    = r_state_q;
        w_credit_d   = r_credit_q;
        w_tmo_d      = '0;
        w_out_d      = 1'b0;
        w_fault_d    = 1'b0;
        w_coin_rej_d = w_coin_any && !w_coin_ok;

        case (r_state_q)
            S_IDLE, S_COLLECT: begin
                if (w_coin_ok) begin
                    w_credit_d = w_coin_sum[4:0];
                    w_state_d  = (w_coin_sum[4:0] >= c_PRICE) ? S_DISPENSE : S_COLLECT;
                end
                // A coin landing together with cancel is counted, then refunded.
                if ((r_state_q == S_COLLECT) && cancel) begin
                    w_state_d = S_CHANGE;
                end
            end
            S_DISPENSE: begin
                if (disp_ack) begin
                    w_credit_d = w_after_vend;
                    w_out_d    = 1'b1;
                    w_state_d  = (w_after_vend != 5'd0) ? S_CHANGE : S_IDLE;
                end else if (r_tmo_q == c_TMO_LAST) begin
                    w_fault_d  = 1'b1;
                    w_state_d  = S_CHANGE;
                end else begin
                    w_tmo_d    = r_tmo_q + c_TMO_ONE;
                end
            end
            S_CHANGE: begin
                if (r_credit_q == 5'd0) begin
                    w_state_d = S_IDLE;
                end else if (chg_ack) begin
                    w_credit_d = r_credit_q - c_COIN5;
                    if (r_credit_q == c_COIN5) begin
                        w_state_d = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_d  = S_IDLE;
                w_credit_d = 5'd0;
            end
        endcase

        w_disp_req_d = (w_state_d == S_DISPENSE);
        w_chg_req_d  = (w_state_d == S_CHANGE) && (w_credit_d != 5'd0);
        w_busy_d     = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q    <= S_IDLE;
            r_credit_q   <= 5'd0;
            r_tmo_q      <= '0;
            r_disp_req_q <= 1'b0;
            r_chg_req_q  <= 1'b0;
            r_out_q      <= 1'b0;
            r_coin_rej_q <= 1'b0;
            r_fault_q    <= 1'b0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_credit_q   <= w_credit_d;
            r_tmo_q      <= w_tmo_d;
            r_disp_req_q <= w_disp_req_d;
            r_chg_req_q  <= w_chg_req_d;
            r_out_q      <= w_out_d;
            r_coin_rej_q <= w_coin_rej_d;
            r_fault_q    <= w_fault_d;
            r_busy_q     <= w_busy_d;
        end
    end

    assign disp_req = r_disp_req_q;
    assign chg_req  = r_chg_req_q;
    assign out      = r_out_q;
    assign coin_rej = r_coin_rej_q;
    assign fault    = r_fault_q;
    assign credit   = r_credit_q;
    assign busy     = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_seq_ctrl
// Description : Directed table-driven bench for vend_seq_ctrl (default params).
// Revision    : 1.0  initial release
// ============================================================================
module tb_vend_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       in5;
    logic       in10;
    logic       cancel;
    logic       disp_ack;
    logic       chg_ack;
    logic       disp_req;
    logic       chg_req;
    logic       out;
    logic       coin_rej;
    logic       fault;
    logic [4:0] credit;
    logic       busy;

    int n_cmp;
    int n_bad;

    // stim = {in5, in10, cancel, disp_ack, chg_ack}
    // exp  = {credit[4:0], disp_req, chg_req, out, coin_rej, fault, busy}
    typedef struct packed {
        logic [4:0]  stim;
        logic [10:0] exp;
    } vec_t;

    localparam int c_NVEC = 24;
    vec_t tbl [c_NVEC];

    vend_seq_ctrl #(
        .PRICE       (15),
        .MAX_CREDIT  (25),
        .ACK_TIMEOUT (16)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in5      (in5),
        .in10     (in10),
        .cancel   (cancel),
        .disp_ack (disp_ack),
        .chg_ack  (chg_ack),
        .disp_req (disp_req),
        .chg_req  (chg_req),
        .out      (out),
        .coin_rej (coin_rej),
        .fault    (fault),
        .credit   (credit),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] pack_out();
        return {credit, disp_req, chg_req, out, coin_rej, fault, busy};
    endfunction

    task automatic drive(input logic [4:0] s);
        {in5, in10, cancel, disp_ack, chg_ack} = s;
    endtask

    task automatic step(input logic [4:0] s);
        @(negedge clk);
        drive(s);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = pack_out();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got credit=%0d dr/cr/out/rej/flt/busy=%b, expected credit=%0d dr/cr/out/rej/flt/busy=%b",
                     name, act[10:6], act[5:0], exp[10:6], exp[5:0]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        drive(5'b00000);

        tbl[0]  = '{5'b10000, {5'd5,  6'b000001}};
        tbl[1]  = '{5'b01000, {5'd15, 6'b100001}};
        tbl[2]  = '{5'b00000, {5'd15, 6'b100001}};
        tbl[3]  = '{5'b00010, {5'd0,  6'b001000}};
        tbl[4]  = '{5'b00000, {5'd0,  6'b000000}};
        tbl[5]  = '{5'b11000, {5'd0,  6'b000100}};
        tbl[6]  = '{5'b00000, {5'd0,  6'b000000}};
        tbl[7]  = '{5'b01000, {5'd10, 6'b000001}};
        tbl[8]  = '{5'b01000, {5'd20, 6'b100001}};
        tbl[9]  = '{5'b01000, {5'd20, 6'b100101}};
        tbl[10] = '{5'b00010, {5'd5,  6'b011001}};
        tbl[11] = '{5'b00001, {5'd0,  6'b000000}};
        tbl[12] = '{5'b01000, {5'd10, 6'b000001}};
        tbl[13] = '{5'b00100, {5'd10, 6'b010001}};
        tbl[14] = '{5'b00100, {5'd10, 6'b010001}};
        tbl[15] = '{5'b00001, {5'd5,  6'b010001}};
        tbl[16] = '{5'b00001, {5'd0,  6'b000000}};
        tbl[17] = '{5'b00001, {5'd0,  6'b000000}};
        tbl[18] = '{5'b10000, {5'd5,  6'b000001}};
        tbl[19] = '{5'b01100, {5'd15, 6'b010001}};
        tbl[20] = '{5'b10001, {5'd10, 6'b010101}};
        tbl[21] = '{5'b00001, {5'd5,  6'b010001}};
        tbl[22] = '{5'b00001, {5'd0,  6'b000000}};
        tbl[23] = '{5'b00010, {5'd0,  6'b000000}};

        // Reset state with coin inputs active to show reset dominates.
        step(5'b01000);
        check("reset_a", {5'd0, 6'b000000});
        step(5'b00000);
        check("reset_b", {5'd0, 6'b000000});
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < c_NVEC; i++) begin
            step(tbl[i].stim);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Dispenser never acknowledges: timeout after 16 cycles in DISPENSE.
        step(5'b10000);
        check("to_coin5", {5'd5, 6'b000001});
        step(5'b01000);
        check("to_enter", {5'd15, 6'b100001});
        for (int i = 0; i < 15; i++) begin
            step(5'b00000);
            check($sformatf("to_wait%0d", i), {5'd15, 6'b100001});
        end
        step(5'b00000);
        check("to_fault", {5'd15, 6'b010011});
        step(5'b00000);
        check("to_fault_once", {5'd15, 6'b010001});
        step(5'b00001);
        check("to_chg1", {5'd10, 6'b010001});
        step(5'b00001);
        check("to_chg2", {5'd5, 6'b010001});
        step(5'b00001);
        check("to_chg3", {5'd0, 6'b000000});

        // Reset in the middle of DISPENSE discards held credit.
        step(5'b01000);
        check("rs_coin1", {5'd10, 6'b000001});
        step(5'b01000);
        check("rs_disp", {5'd20, 6'b100001});
        @(negedge clk);
        rst = 1'b0;
        drive(5'b00010);
        @(posedge clk);
        #1;
        check("rs_clear", {5'd0, 6'b000000});
        @(negedge clk);
        rst = 1'b1;
        step(5'b00010);
        check("rs_ack_ignored", {5'd0, 6'b000000});

        // Reset in the middle of CHANGE.
        step(5'b01000);
        check("rc_coin", {5'd10, 6'b000001});
        step(5'b00100);
        check("rc_cancel", {5'd10, 6'b010001});
        @(negedge clk);
        rst = 1'b0;
        drive(5'b00001);
        @(posedge clk);
        #1;
        check("rc_clear", {5'd0, 6'b000000});
        @(negedge clk);
        rst = 1'b1;
        step(5'b10000);
        check("rc_first_coin", {5'd5, 6'b000001});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
